// File: rtl/shift_add_mul_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per clock, LSB first.
// Optional macro SIGNED_MUL_EN adds the is_signed port for two's-complement products.
`timescale 1ns/1ps
module shift_add_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MUL_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul,
  output logic               busy,
  output logic [1:0]         dbg_state_o
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready depends only on registered state, and out_valid/mul hold until out_ready.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_init, addend;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]   mul_q;
  logic            sgn;
  logic            accept;
  logic            last_bit;

  assign accept   = in_ready && in_valid;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SIGNED_MUL_EN
  logic sgn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_q <= 1'b0;
    end else if (accept) begin
      sgn_q <= is_signed;
    end
  end

  assign sgn        = sgn_q;
  assign mcand_init = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
`else
  assign sgn        = 1'b0;
  assign mcand_init = {{WIDTH{1'b0}}, a};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    dbg_state_o = state_q;
  end

  // The multiplier MSB carries negative weight in signed mode, so its term is subtracted.
  always_comb begin
    addend = mplier_q[0] ? mcand_q : '0;
    acc_d  = (sgn && last_bit) ? (acc_q - addend) : (acc_q + addend);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_q    <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= mcand_init;
      mplier_q <= b;
    end else if (state_q == ST_RUN) begin
      cnt_q    <= cnt_q + CW'(1);
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (last_bit) begin
        mul_q <= acc_d;
      end
    end
  end

  assign mul = mul_q;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// Bench for shift_add_mul_seq: directed vectors, expected products queued at acceptance
// and checked by an independent output monitor; SIGNED_MUL_EN adds signed vectors.
`timescale 1ns/1ps
module tb_shift_add_mul_seq;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        is_s;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] mul;
  logic        busy;
  logic [1:0]  dbg_state;

  logic        in_valid16, in_ready16, out_valid16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] mul16;
  logic [1:0]  dbg16;
  logic        in_valid2, in_ready2, out_valid2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  mul2;
  logic [1:0]  dbg2;
  logic        side_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] exp_q[$];
  int          acc_cyc_q[$];
  logic [15:0] cur_exp = '0;
  int          cur_acc = 0;
  logic        prev_ov = 1'b0;
  logic        prev_xfer = 1'b0;

  shift_add_mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef SIGNED_MUL_EN
    .is_signed(is_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .mul(mul), .busy(busy), .dbg_state_o(dbg_state)
  );

  shift_add_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
`ifdef SIGNED_MUL_EN
    .is_signed(1'b0),
`endif
    .out_valid(out_valid16), .out_ready(side_ready), .mul(mul16), .busy(busy16), .dbg_state_o(dbg16)
  );

  shift_add_mul_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
`ifdef SIGNED_MUL_EN
    .is_signed(1'b0),
`endif
    .out_valid(out_valid2), .out_ready(side_ready), .mul(mul2), .busy(busy2), .dbg_state_o(dbg2)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: presents one operand pair and records the expectation at the acceptance edge.
  // With hold set, in_valid stays high with junk operands until the block is idle again.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      input logic [15:0] ev, input bit hold);
    int w = 0;
    a = av; b = bv; is_s = sv; in_valid = 1'b1;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready=0 required=1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(ev);
      acc_cyc_q.push_back(cyc);
      if (hold) begin
        w = 0;
        while (!in_ready && w < 200) begin
          a = 8'($urandom); b = 8'($urandom); is_s = 1'($urandom);
          @(negedge clk); w++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || out_valid || !in_ready) && w < 300) begin
      @(negedge clk); w++;
    end
    if (w >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic side16(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev);
    int w = 0;
    int acc;
    a16 = av; b16 = bv; in_valid16 = 1'b1;
    while (!in_ready16 && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    acc = cyc; in_valid16 = 1'b0; w = 0;
    while (!out_valid16 && w < 100) begin @(negedge clk); w++; end
    check("w16_product", mul16, ev);
    check("w16_latency", cyc - acc, 16);
  endtask

  task automatic side2(input logic [1:0] av, input logic [1:0] bv, input logic [3:0] ev);
    int w = 0;
    int acc;
    a2 = av; b2 = bv; in_valid2 = 1'b1;
    while (!in_ready2 && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    acc = cyc; in_valid2 = 1'b0; w = 0;
    while (!out_valid2 && w < 100) begin @(negedge clk); w++; end
    check("w2_product", 32'(mul2), 32'(ev));
    check("w2_latency", cyc - acc, 2);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      if (prev_xfer) begin
        check("in_ready_after_xfer", 32'(in_ready), 32'd1);
        check("out_valid_drop", 32'(out_valid), 32'd0);
      end else if (prev_ov) begin
        check("out_valid_hold", 32'(out_valid), 32'd1);
      end
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output mul=%0h expected no output", mul);
        end else begin
          cur_exp = exp_q.pop_front();
          cur_acc = acc_cyc_q.pop_front();
          check("product", 32'(mul), 32'(cur_exp));
          check("latency", cyc - cur_acc, W);
        end
      end else if (out_valid && prev_ov) begin
        check("mul_stable", 32'(mul), 32'(cur_exp));
      end
      if (out_valid) check("busy_in_done", 32'(busy), 32'd1);
      prev_xfer = out_valid && out_ready;
      prev_ov   = out_valid;
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; is_s = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; in_valid2 = 1'b0; a2 = '0; b2 = '0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mul", 32'(mul), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Unsigned directed vectors, including operands changing during RUN/DONE
    send(8'd13, 8'd11, 1'b0, 16'd143,   1'b0);
    send(8'hA5, 8'h5A, 1'b0, 16'h3A02,  1'b0);
    send(8'h55, 8'hAA, 1'b0, 16'h3872,  1'b1);
    send(8'h07, 8'h80, 1'b0, 16'h0380,  1'b1);
    send(8'hFF, 8'h01, 1'b0, 16'h00FF,  1'b0);
    send(8'h00, 8'hFF, 1'b0, 16'h0000,  1'b0);
    send(8'hFF, 8'h02, 1'b0, 16'h01FE,  1'b0);
    send(8'h01, 8'h01, 1'b0, 16'h0001,  1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("mul_retained_idle", 32'(mul), 32'h0001);

    // Back-pressure: product held with out_valid high for 5 cycles
    out_ready = 1'b0;
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0);
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    repeat (5) @(negedge clk);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

`ifdef SIGNED_MUL_EN
    send(8'h80, 8'h80, 1'b1, 16'h4000, 1'b0);
    send(8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0);
    send(8'h7F, 8'h80, 1'b1, 16'hC080, 1'b0);
    send(8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0);
    send(8'h80, 8'h80, 1'b0, 16'h4000, 1'b0);
    send(8'hFD, 8'h05, 1'b0, 16'h04F1, 1'b0);
    drain();
`endif

    // Reset during RUN cycle 4 aborts the operation
    send(8'd13, 8'd11, 1'b0, 16'd143, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    acc_cyc_q.delete();
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_mul", 32'(mul), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h0C, 8'h0C, 1'b0, 16'h0090, 1'b0);
    drain();

    // Width boundaries
    side16(16'h0000, 16'hFFFF, 32'h0000_0000);
    side16(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    side2(2'b11, 2'b11, 4'd9);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
